// File: rtl/prio_enc_pkg.sv
// Package for the pipelined priority encoder.
// Holds the index-width helper and the registered result record.
// The result record carries a fixed-width index field wide enough for any
// practical N; the top level uses only the low W bits of it.
// Optional feature macro used by this slice: PRIO_ENC_RR_EN (round-robin).
package prio_enc_pkg;

  // Upper bound on the index width carried in the result record.
  localparam int IDX_MAX_W = 16;

  // Index width for n requesters (n >= 2 gives $clog2(n) >= 1).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [IDX_MAX_W-1:0] idx;   // winning index (low bits used)
    logic                 any;   // at least one request bit set
    logic                 multi; // two or more request bits set
  } result_t;

endpackage

// File: rtl/prio_enc_find.sv
// Combinational core of the priority encoder.
// Ports:
//   req   [N]  request vector, bit i = requester i
//   ptr   [W]  search start index (0 gives lowest-index priority)
//   idx   [W]  first set bit at or above ptr, wrapping past N-1 to 0
//   any        at least one bit of req set
//   multi      two or more bits of req set (independent of ptr)
// Macro: none (the caller ties ptr to 0 when round-robin is disabled).
module prio_enc_find
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         multi
);

  logic found;

  // NOTE: every signal driven here gets a default before the loop so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      // Walk upward from ptr with modular wrap; valid for any N.
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = W'(j);
      end
    end
  end

  assign any = |req;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(req & (req - N'(1)));

endmodule

// File: rtl/prio_encoder_pipe.sv
// Registered N-input priority encoder with valid/ready on both sides.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake; in_ready = !out_valid || out_ready
//   in_req    [N]        request vector
//   out_valid/out_ready  output handshake
//   out_idx   [W]        winning index
//   out_any              at least one captured request bit set
//   out_multi            two or more captured request bits set
// Macro PRIO_ENC_RR_EN: when defined, priority rotates past each accepted
// non-zero winner; when undefined, bit 0 always has the highest priority.
module prio_encoder_pipe
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  localparam int W = idx_w(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_any,
  output logic         out_multi
);

  logic          in_acc;
  logic          out_acc;
  logic [W-1:0]  ptr;
  logic [W-1:0]  find_idx;
  logic          find_any;
  logic          find_multi;
  result_t       res_d;
  result_t       res_q;

  // Single output register: a new vector fits when the slot is empty or
  // is being drained on this same edge.
  assign in_ready = !out_valid || out_ready;
  assign in_acc   = in_valid && in_ready;
  assign out_acc  = out_valid && out_ready;

  prio_enc_find #(.N(N), .W(W)) u_find (
    .req   (in_req),
    .ptr   (ptr),
    .idx   (find_idx),
    .any   (find_any),
    .multi (find_multi)
  );

  always_comb begin
    res_d       = '0;
    res_d.idx   = IDX_MAX_W'(find_idx);
    res_d.any   = find_any;
    res_d.multi = find_multi;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering.
  // The result register is reset too: reset values of the outputs are visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res_q     <= '0;
    end else if (in_acc) begin
      out_valid <= 1'b1;
      res_q     <= res_d;
    end else if (out_acc) begin
      out_valid <= 1'b0;
    end
  end

`ifdef PRIO_ENC_RR_EN
  // Pointer moves on the output accept edge, so a vector loaded on that
  // same edge was encoded with the old pointer. Zero beats leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (out_acc && res_q.any) begin
      ptr <= (int'(out_idx) == N - 1) ? '0 : out_idx + W'(1);
    end
  end
`else
  assign ptr = '0;
`endif

  assign out_idx   = res_q.idx[W-1:0];
  assign out_any   = res_q.any;
  assign out_multi = res_q.multi;

endmodule
